// File: rtl/word_arbiter_2to1_pkg.sv
// Shared types for the two-requester word arbiter.
// State encoding and requester IDs.
package word_arbiter_2to1_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/word_arbiter_2to1_mux.sv
// 32-bit two-input select feeding the arbiter's output register.
// sel=0 picks inA, sel=1 picks inB.
module Mux32Bit2To1 (
    input  logic [31:0] inA,
    input  logic [31:0] inB,
    input  logic        sel,
    output logic [31:0] out
);

    assign out = sel ? inB : inA;

endmodule

// File: rtl/word_arbiter_2to1.sv
// Round-robin 2:1 word arbiter with a single registered output slot.
// Readies are combinational; out_* come straight from registers.
module word_arbiter_2to1
    import word_arbiter_2to1_pkg::*;
#(
    parameter logic FIRST_PRIO = 1'b0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        a_valid,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [31:0] b_data,
    output logic        b_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic        out_src
);

    state_t      state;
    logic        last_grant;
    logic        winner;
    logic        load_en;
    logic        hs;
    logic [31:0] mux_data;

    always_comb begin
        winner = SRC_A;
        unique case ({a_valid, b_valid})
            2'b10:   winner = SRC_A;
            2'b01:   winner = SRC_B;
            2'b11:   winner = ~last_grant;
            default: winner = SRC_A;
        endcase
    end

    // Reset gates the readies so nothing handshakes while held in reset.
    assign load_en = Reset & ((state == IDLE) | out_ready);
    assign a_ready = load_en & a_valid & (winner == SRC_A);
    assign b_ready = load_en & b_valid & (winner == SRC_B);
    assign hs      = a_ready | b_ready;

    Mux32Bit2To1 u_mux (
        .inA (a_data),
        .inB (b_data),
        .sel (winner),
        .out (mux_data)
    );

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state      <= IDLE;
            out_data   <= 32'h0;
            out_src    <= SRC_A;
            last_grant <= ~FIRST_PRIO;
        end else if (load_en) begin
            if (hs) begin
                state      <= FULL;
                out_data   <= mux_data;
                out_src    <= winner;
                last_grant <= winner;
            end else begin
                state <= IDLE;
            end
        end
    end

    assign out_valid = (state == FULL);

endmodule

// File: tb/tb_word_arbiter_2to1.sv
// Directed scoreboard bench for word_arbiter_2to1.
// Stimulus pushes expected words; a monitor pops them on output handshakes.
module tb_word_arbiter_2to1;

    logic        Clk;
    logic        Reset;
    logic        a_valid;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [31:0] b_data;
    logic        b_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        out_src;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [32:0] exp_q[$];

    word_arbiter_2to1 #(.FIRST_PRIO(1'b0)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_src   (out_src)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [32:0] act,
                       input logic [32:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    // One cycle: drive at negedge, check readies, record expected word.
    task automatic step(input logic rst, input logic av, input logic [31:0] ad,
                        input logic bv, input logic [31:0] bd, input logic ordy,
                        input logic ear, input logic ebr);
        @(negedge Clk);
        Reset = rst;
        a_valid = av;
        a_data = ad;
        b_valid = bv;
        b_data = bd;
        out_ready = ordy;
        #1;
        chk("a_ready", {32'h0, a_ready}, {32'h0, ear});
        chk("b_ready", {32'h0, b_ready}, {32'h0, ebr});
        if (ear) exp_q.push_back({1'b0, ad});
        if (ebr) exp_q.push_back({1'b1, bd});
        @(posedge Clk);
        #1;
    endtask

    // Monitor: consumer takes a word whenever out_valid & out_ready.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge Clk);
            #2;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_word: got %h expected none",
                             {out_src, out_data});
                end else begin
                    e = exp_q.pop_front();
                    chk("out_word", {out_src, out_data}, e);
                end
            end
        end
    end

    initial begin
        Reset = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_data = 32'h0;
        b_data = 32'h0;
        out_ready = 1'b0;

        // Reset held with both requesters valid
        step(0, 1, 32'hAAAA0001, 1, 32'hBBBB0001, 0, 0, 0);
        step(0, 1, 32'hAAAA0001, 1, 32'hBBBB0001, 0, 0, 0);
        chk("rst_out_valid", {32'h0, out_valid}, 33'h0);
        chk("rst_out_data", {1'b0, out_data}, 33'h0);
        chk("rst_out_src", {32'h0, out_src}, 33'h0);

        // Contention: A,B,A,B one per cycle
        step(1, 1, 32'hAAAA0001, 1, 32'hBBBB0001, 1, 1, 0);
        chk("cont_src0", {32'h0, out_src}, 33'h0);
        step(1, 1, 32'hAAAA0001, 1, 32'hBBBB0001, 1, 0, 1);
        chk("cont_src1", {32'h0, out_src}, 33'h1);
        step(1, 1, 32'hAAAA0001, 1, 32'hBBBB0001, 1, 1, 0);
        chk("cont_src2", {32'h0, out_src}, 33'h0);
        step(1, 1, 32'hAAAA0001, 1, 32'hBBBB0001, 1, 0, 1);
        chk("cont_src3", {32'h0, out_src}, 33'h1);
        step(1, 0, 32'h0, 0, 32'h0, 1, 0, 0);
        chk("cont_idle", {32'h0, out_valid}, 33'h0);

        // Backpressure
        step(1, 1, 32'h12345678, 0, 32'h0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 32'h11111111, 1, 32'h22222222, 0, 0, 0);
            chk("bp_valid", {32'h0, out_valid}, 33'h1);
            chk("bp_data", {1'b0, out_data}, {1'b0, 32'h12345678});
        end
        step(1, 0, 32'h0, 0, 32'h0, 1, 0, 0);
        chk("bp_drained", {32'h0, out_valid}, 33'h0);

        // Drain to idle after single B word
        step(1, 0, 32'h0, 1, 32'h0000BEEF, 1, 0, 1);
        chk("drain_full", {32'h0, out_valid}, 33'h1);
        step(1, 0, 32'h0, 0, 32'h0, 1, 0, 0);
        chk("drain_idle", {32'h0, out_valid}, 33'h0);

        // Lone requester A, then B joins and wins
        for (int i = 0; i < 5; i++)
            step(1, 1, 32'hA0000000 + i, 0, 32'h0, 1, 1, 0);
        step(1, 1, 32'hA0000005, 1, 32'hB0000001, 1, 0, 1);
        step(1, 1, 32'hA0000005, 0, 32'h0, 1, 1, 0);
        step(1, 0, 32'h0, 0, 32'h0, 1, 0, 0);

        // Mid-operation reset discards the held word
        step(1, 1, 32'hDEADBEEF, 0, 32'h0, 0, 1, 0);
        void'(exp_q.pop_back());
        chk("mr_full", {32'h0, out_valid}, 33'h1);
        chk("mr_data", {1'b0, out_data}, {1'b0, 32'hDEADBEEF});
        step(0, 1, 32'hAAAA0002, 1, 32'hBBBB0002, 0, 0, 0);
        chk("mr_valid", {32'h0, out_valid}, 33'h0);
        chk("mr_data0", {1'b0, out_data}, 33'h0);
        step(1, 1, 32'hAAAA0002, 1, 32'hBBBB0002, 1, 1, 0);
        chk("mr_src", {32'h0, out_src}, 33'h0);
        step(1, 0, 32'h0, 0, 32'h0, 1, 0, 0);
        step(1, 0, 32'h0, 0, 32'h0, 0, 0, 0);

        chk("queue_empty", 33'(exp_q.size()), 33'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
